packet_tx_arbiter: RTL

PACKET_TX_ARBITER -- requirements
Module: packet_tx_arbiter

---
 rtl/Structures.sv | 39 +++
 rtl/rr_picker2.sv | 27 ++
 rtl/packet_tx_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/Structures.sv
// -----------------------------------------------------------------------------
// Structures -- shared type package for the UART packet datapath.
//
// Contents:
//   UART_PACKET      one byte of a framed packet plus its sideband fields
//   ArbState         state encoding for the transmit arbiter (IDLE/GRANT/SEND)
//   TIMEOUT_DEFAULT  default idle-cycle limit inside a granted packet
//   satInc8          saturating 8-bit increment used by event counters
// -----------------------------------------------------------------------------
package Structures;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } ArbState;

    localparam int TIMEOUT_DEFAULT = 1024;

    // Counts stick at 255 instead of wrapping back to zero.
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/rr_picker2.sv
// -----------------------------------------------------------------------------
// rr_picker2 -- two-input round-robin choice.
//
// Ports:
//   reqA, reqB   requests from the two contenders
//   lastWinner   who won last time (0 = A, 1 = B)
//   winner       chosen contender (0 = A, 1 = B); 0 when nobody requests
// -----------------------------------------------------------------------------
module rr_picker2 (
    input  logic reqA,
    input  logic reqB,
    input  logic lastWinner,
    output logic winner
);

    // A lone requester wins; on a tie the one that did not win last time goes.
    always_comb begin
        winner = 1'b0;
        case ({reqA, reqB})
            2'b10:   winner = 1'b0;
            2'b01:   winner = 1'b1;
            2'b11:   winner = ~lastWinner;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/packet_tx_arbiter.sv
// -----------------------------------------------------------------------------
// packet_tx_arbiter -- arbitrates two packet sources onto one UART transmitter.
//
// A whole packet (SoP .. EoP) from the granted source is forwarded one byte at
// a time through a single holding register; the other source waits until the
// packet ends or the owner goes idle for TIMEOUT cycles.
//
// Ports:
//   ipClk, ipReset          clock, asynchronous active-low reset
//   ipStreamA / opReadyA    requester A (read responses) and its accept strobe
//   ipStreamB / opReadyB    requester B (write acks) and its accept strobe
//   ipTxReady               UART transmitter can take a byte
//   opTxStream              arbitrated byte stream (Valid is a 1-cycle pulse)
//   opGrant                 current owner, 0 = A, 1 = B
//   opBusy                  a packet is granted
//   opTimeoutCount          number of revoked grants, saturating at 255
// -----------------------------------------------------------------------------
module packet_tx_arbiter
    import Structures::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  UART_PACKET ipStreamA,
    input  UART_PACKET ipStreamB,
    output logic       opReadyA,
    output logic       opReadyB,
    input  logic       ipTxReady,
    output UART_PACKET opTxStream,
    output logic       opGrant,
    output logic       opBusy,
    output logic [7:0] opTimeoutCount
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ArbState          state;
    ArbState          nextState;
    UART_PACKET       holdReg;
    UART_PACKET       ownerStream;
    UART_PACKET       txLoad;
    logic [CNT_W-1:0] timeoutCnt;
    logic             lastWinner;
    logic             reqA;
    logic             reqB;
    logic             pickWinner;
    logic             accept;
    logic             timeoutHit;

    // Only a start-of-packet byte counts as a bid for the transmitter.
    assign reqA = ipStreamA.Valid & ipStreamA.SoP;
    assign reqB = ipStreamB.Valid & ipStreamB.SoP;

    assign ownerStream = opGrant ? ipStreamB : ipStreamA;
    assign accept      = (state == GRANT) & ownerStream.Valid;
    assign timeoutHit  = (state == GRANT) & ~ownerStream.Valid & (timeoutCnt == CNT_LAST);

    rr_picker2 u_picker (
        .reqA       (reqA),
        .reqB       (reqB),
        .lastWinner (lastWinner),
        .winner     (pickWinner)
    );

    // Held byte as it goes out on the wire: all fields unchanged, Valid raised.
    always_comb begin
        txLoad       = holdReg;
        txLoad.Valid = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (reqA | reqB) begin
                    nextState = GRANT;
                end else begin
                    nextState = IDLE;
                end
            end
            GRANT: begin
                if (accept) begin
                    nextState = SEND;
                end else if (timeoutHit) begin
                    nextState = IDLE;
                end else begin
                    nextState = GRANT;
                end
            end
            SEND: begin
                if (ipTxReady) begin
                    nextState = holdReg.EoP ? IDLE : GRANT;
                end else begin
                    nextState = SEND;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: only the owner is offered an accept, and only in GRANT.
    always_comb begin
        opReadyA = 1'b0;
        opReadyB = 1'b0;
        case (state)
            GRANT: begin
                opReadyA = ~opGrant;
                opReadyB = opGrant;
            end
            default: begin
                opReadyA = 1'b0;
                opReadyB = 1'b0;
            end
        endcase
    end

    // Datapath: grant bookkeeping, holding register, output stream, timeout.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            holdReg        <= '0;
            opTxStream     <= '0;
            opGrant        <= 1'b0;
            opBusy         <= 1'b0;
            opTimeoutCount <= 8'd0;
            timeoutCnt     <= '0;
            lastWinner     <= 1'b1;
        end else begin
            // Valid is a single-cycle pulse; the other fields keep their value.
            opTxStream.Valid <= 1'b0;
            case (state)
                IDLE: begin
                    // opBusy stays high through the EoP pulse cycle and
                    // drops here unless a new packet is granted at once.
                    opBusy     <= reqA | reqB;
                    timeoutCnt <= '0;
                    if (reqA | reqB) begin
                        opGrant <= pickWinner;
                    end else begin
                        opGrant <= opGrant;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        holdReg    <= ownerStream;
                        timeoutCnt <= '0;
                    end else if (timeoutHit) begin
                        timeoutCnt     <= '0;
                        opBusy         <= 1'b0;
                        lastWinner     <= opGrant;
                        opTimeoutCount <= satInc8(opTimeoutCount);
                    end else begin
                        timeoutCnt <= timeoutCnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    // The timeout counter is frozen while the UART stalls us.
                    if (ipTxReady) begin
                        opTxStream <= txLoad;
                        if (holdReg.EoP) begin
                            lastWinner <= opGrant;
                        end else begin
                            lastWinner <= lastWinner;
                        end
                    end else begin
                        holdReg <= holdReg;
                    end
                end
                default: begin
                    timeoutCnt <= '0;
                end
            endcase
        end
    end

endmodule
